// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pkg
// Purpose  : Opcodes, FSM states and flag bit positions shared by alu_mc.
// Revision : 1.0
// ============================================================================
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_NOR  = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // Bit positions inside flags = {Z,N,C,V}
    localparam int c_flag_z = 3;
    localparam int c_flag_n = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

endpackage
`default_nettype wire

// File: rtl/alu_mc_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_mul
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle,
//            low WIDTH bits of the product. Used only with ALU_MC_MUL_EN.
// Revision : 1.0
// ============================================================================
module alu_mc_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int c_cnt_w = $clog2(WIDTH);

    logic               r_busy_q,   w_busy_d;
    logic [c_cnt_w-1:0] r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0]   r_mcand_q,  w_mcand_d;
    logic [WIDTH-1:0]   r_mplier_q, w_mplier_d;
    logic [WIDTH-1:0]   r_acc_q,    w_acc_d;
    logic [WIDTH-1:0]   w_acc_next;

    // product is the accumulator including the current step, so it is
    // final in the same cycle done is raised.
    assign w_acc_next = r_acc_q + (r_mplier_q[0] ? r_mcand_q : '0);
    assign busy       = r_busy_q;
    assign done       = r_busy_q && (r_cnt_q == c_cnt_w'(WIDTH - 1));
    assign product    = w_acc_next;

    always_comb begin
        w_busy_d   = r_busy_q;
        w_cnt_d    = r_cnt_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_acc_d    = r_acc_q;
        if (start) begin
            w_busy_d   = 1'b1;
            w_cnt_d    = '0;
            w_mcand_d  = a;
            w_mplier_d = b;
            w_acc_d    = '0;
        end else if (r_busy_q) begin
            w_acc_d    = w_acc_next;
            w_mcand_d  = r_mcand_q << 1;
            w_mplier_d = r_mplier_q >> 1;
            w_cnt_d    = r_cnt_q + 1'b1;
            if (done) begin
                w_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy_q   <= 1'b0;
            r_cnt_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_acc_q    <= '0;
        end else begin
            r_busy_q   <= w_busy_d;
            r_cnt_q    <= w_cnt_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_acc_q    <= w_acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with valid/ready handshakes and {Z,N,C,V} flags.
//            Define ALU_MC_MUL_EN to include the iterative multiplier (op 11).
// Revision : 1.0
// ============================================================================
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int c_sh_w = $clog2(WIDTH);
    localparam int c_msb  = WIDTH - 1;

    alu_state_e       r_state_q,     w_state_d;
    logic [WIDTH-1:0] r_a_q,         w_a_d;
    logic [WIDTH-1:0] r_b_q,         w_b_d;
    logic [3:0]       r_op_q,        w_op_d;
    logic [WIDTH-1:0] r_result_q,    w_result_d;
    logic [3:0]       r_flags_q,     w_flags_d;
    logic             r_err_q,       w_err_d;
    logic             r_out_valid_q, w_out_valid_d;

    logic             w_accept;
    logic [c_sh_w-1:0] w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic [3:0]       w_alu_flags;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_alu_err;

`ifdef ALU_MC_MUL_EN
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    alu_mc_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    assign in_ready = (r_state_q == ST_IDLE) && !w_mul_busy;
`else
    assign in_ready = (r_state_q == ST_IDLE);
`endif

    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid_q;
    assign result    = r_result_q;
    assign flags     = r_flags_q;
    assign err       = r_err_q;

    // The extra top bit of the subtraction is the unsigned borrow.
    assign w_sh   = r_b_q[c_sh_w-1:0];
    assign w_sum  = {1'b0, r_a_q} + {1'b0, r_b_q};
    assign w_diff = {1'b0, r_a_q} - {1'b0, r_b_q};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_err = 1'b0;
        case (r_op_q)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (r_a_q[c_msb] == r_b_q[c_msb]) && (w_sum[c_msb] != r_a_q[c_msb]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (r_a_q[c_msb] != r_b_q[c_msb]) && (w_diff[c_msb] != r_a_q[c_msb]);
            end
            OP_AND:  w_alu_res = r_a_q & r_b_q;
            OP_OR:   w_alu_res = r_a_q | r_b_q;
            OP_NOR:  w_alu_res = ~(r_a_q | r_b_q);
            OP_XOR:  w_alu_res = r_a_q ^ r_b_q;
            OP_SLL:  w_alu_res = r_a_q << w_sh;
            OP_SRL:  w_alu_res = r_a_q >> w_sh;
            OP_SRA:  w_alu_res = $signed(r_a_q) >>> w_sh;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a_q) < $signed(r_b_q))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (r_a_q < r_b_q)};
            default: w_alu_err = 1'b1;
        endcase
    end

    always_comb begin
        w_alu_flags = '0;
        if (!w_alu_err) begin
            w_alu_flags[c_flag_z] = (w_alu_res == '0);
            w_alu_flags[c_flag_n] = w_alu_res[c_msb];
            w_alu_flags[c_flag_c] = w_alu_c;
            w_alu_flags[c_flag_v] = w_alu_v;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_op_d     = r_op_q;
        w_result_d = r_result_q;
        w_flags_d  = r_flags_q;
        w_err_d    = r_err_q;
`ifdef ALU_MC_MUL_EN
        w_mul_start = 1'b0;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_a_d  = a;
                    w_b_d  = b;
                    w_op_d = op;
`ifdef ALU_MC_MUL_EN
                    if (op == OP_MUL) begin
                        w_state_d   = ST_MUL;
                        w_mul_start = 1'b1;
                    end else begin
                        w_state_d = ST_EXEC;
                    end
`else
                    w_state_d = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                w_result_d = w_alu_res;
                w_flags_d  = w_alu_flags;
                w_err_d    = w_alu_err;
                w_state_d  = ST_DONE;
            end
`ifdef ALU_MC_MUL_EN
            ST_MUL: begin
                if (w_mul_done) begin
                    w_result_d           = w_mul_product;
                    w_flags_d            = '0;
                    w_flags_d[c_flag_z]  = (w_mul_product == '0);
                    w_flags_d[c_flag_n]  = w_mul_product[c_msb];
                    w_err_d              = 1'b0;
                    w_state_d            = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        w_out_valid_d = (w_state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_op_q        <= '0;
            r_result_q    <= '0;
            r_flags_q     <= '0;
            r_err_q       <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_op_q        <= w_op_d;
            r_result_q    <= w_result_d;
            r_flags_q     <= w_flags_d;
            r_err_q       <= w_err_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=16), directed corner cases
//            plus randomized traffic against a transaction-level model.
//            Honours ALU_MC_MUL_EN the same way as the design.
// Revision : 1.0
// ============================================================================
module tb_alu_mc;

`ifdef ALU_MC_MUL_EN
    localparam bit c_mul_en = 1'b1;
`else
    localparam bit c_mul_en = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    alu_mc #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference semantics from plain integer arithmetic.
    function automatic void ref_alu(input logic [15:0] xa, input logic [15:0] xb, input logic [3:0] xop,
                                    output logic [15:0] r, output logic [3:0] f, output bit e);
        longint ua, ub, sa, sb, t;
        int sh;
        bit c, v;
        ua = longint'(xa);
        ub = longint'(xb);
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        sh = int'(xb[3:0]);
        c = 0; v = 0; e = 0; r = 16'h0;
        case (xop)
            4'd0: begin t = ua + ub; r = t[15:0]; c = (t > 65535); t = sa + sb; v = (t > 32767) || (t < -32768); end
            4'd1: begin t = ua - ub; r = t[15:0]; c = (ua < ub);   t = sa - sb; v = (t > 32767) || (t < -32768); end
            4'd2: r = xa & xb;
            4'd3: r = xa | xb;
            4'd4: r = ~(xa | xb);
            4'd5: r = xa ^ xb;
            4'd6: begin t = ua * (longint'(1) << sh); r = t[15:0]; end
            4'd7: begin t = ua / (longint'(1) << sh); r = t[15:0]; end
            4'd8: begin t = sa >>> sh; r = t[15:0]; end
            4'd9: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd10: r = (ua < ub) ? 16'd1 : 16'd0;
            4'd11: begin
                if (c_mul_en) begin t = ua * ub; r = t[15:0]; end
                else e = 1;
            end
            default: e = 1;
        endcase
        if (e) begin
            r = 16'h0;
            f = 4'h0;
        end else begin
            f = {(r == 16'h0), r[15], c, v};
        end
    endfunction

    function automatic int lat_of(input logic [3:0] xop);
        return (c_mul_en && xop == 4'd11) ? 17 : 2;
    endfunction

    // Transaction model: one request in flight, result due at a given cycle.
    bit          m_busy;
    int          m_due;
    logic [15:0] m_res, m_res_last;
    logic [3:0]  m_flg, m_flg_last;
    bit          m_err, m_err_last;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_due = 0;
            m_res = 0; m_flg = 0; m_err = 0;
            m_res_last = 0; m_flg_last = 0; m_err_last = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                ref_alu(a, b, op, m_res, m_flg, m_err);
                m_busy = 1;
                m_due  = cyc + lat_of(op);
            end
        end else if (cyc >= m_due && out_ready) begin
            m_busy     = 0;
            m_res_last = m_res;
            m_flg_last = m_flg;
            m_err_last = m_err;
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            automatic bit ov = m_busy && (cyc >= m_due);
            chk("in_ready",  in_ready,  !m_busy);
            chk("out_valid", out_valid, ov);
            chk("result",    result,    ov ? m_res : m_res_last);
            chk("flags",     flags,     ov ? m_flg : m_flg_last);
            chk("err",       err,       ov ? m_err : m_err_last);
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (in_ready !== 1'b1 && n < 60) begin @(negedge clock); n++; end
        if (in_ready !== 1'b1) chk({nm, "_idle_timeout"}, in_ready, 1);
    endtask

    task automatic txn(input logic [15:0] xa, input logic [15:0] xb, input logic [3:0] xop,
                       input int hold, input int lat, input logic [15:0] er,
                       input logic [3:0] ef, input bit ee, input string nm);
        int t0, n;
        wait_idle(nm);
        in_valid = 1; a = xa; b = xb; op = xop; out_ready = 0;
        t0 = cyc;
        @(negedge clock);
        in_valid = 0;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin @(negedge clock); n++; end
        chk({nm, "_latency"}, cyc - t0, lat);
        chk({nm, "_result"}, result, er);
        chk({nm, "_flags"},  flags,  ef);
        chk({nm, "_err"},    err,    ee);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
            @(negedge clock);
            chk({nm, "_hold_result"}, result, er);
            chk({nm, "_hold_flags"},  flags,  ef);
            chk({nm, "_hold_ready"},  in_ready, 0);
        end
        out_ready = 1; in_valid = 1;
        @(negedge clock);
        out_ready = 0; in_valid = 0;
        chk({nm, "_back_idle"}, in_ready, 1);
        chk({nm, "_valid_drop"}, out_valid, 0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1; in_valid = 0; a = 0; b = 0; op = 0; out_ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    result,    0);
        chk("rst_flags",     flags,     0);
        chk("rst_err",       err,       0);

        txn(16'hFFFF, 16'h0001, 4'd0, 5, 2, 16'h0000, 4'b1010, 0, "add_carry");
        txn(16'h8000, 16'h0001, 4'd1, 0, 2, 16'h7FFF, 4'b0001, 0, "sub_ovf");
        txn(16'h8000, 16'h0004, 4'd8, 0, 2, 16'hF800, 4'b0100, 0, "sra");
        if (c_mul_en) txn(16'h0012, 16'h0034, 4'd11, 1, 17, 16'h03A8, 4'b0000, 0, "mul");
        else          txn(16'h0012, 16'h0034, 4'd11, 1, 2,  16'h0000, 4'b0000, 1, "mul_off");
        txn(16'h1234, 16'h5678, 4'hC, 2, 2, 16'h0000, 4'b0000, 1, "illegal");
        txn(16'hFFFF, 16'h0001, 4'd9,  0, 2, 16'h0001, 4'b0000, 0, "slt");
        txn(16'hFFFF, 16'h0001, 4'd10, 0, 2, 16'h0000, 4'b1000, 0, "sltu");

        // Abort a multi-cycle operation with reset.
        wait_idle("abort");
        in_valid = 1; a = 16'h0012; b = 16'h0034; op = 4'd11; t0 = cyc;
        @(negedge clock);
        in_valid = 0;
        while (cyc < t0 + (c_mul_en ? 5 : 1)) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 20; i++) begin
            chk("abort_no_valid", out_valid, 0);
            @(negedge clock);
        end
        chk("abort_result", result, 0);
        chk("abort_flags",  flags,  0);
        chk("abort_err",    err,    0);
        txn(16'h0002, 16'h0003, 4'd0, 0, 2, 16'h0005, 4'b0000, 0, "add_after_rst");

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            a         = pick();
            b         = pick();
            op        = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clock);
        end
        in_valid = 0; out_ready = 1;
        repeat (40) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
